// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller in front of a single-port registered-read RAM.
// Optional macro SRAM_FIFO_BYPASS_EN: pushes into an empty FIFO load the output register directly.
module sram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic read_issue;
  logic push;
  logic pop;
  logic bypass;

  // The RAM read takes priority over a write; a waiting push simply stalls a cycle.
  assign read_issue = (state_q == IDLE) && !out_valid_q && (mem_count_q != '0);
  assign in_ready   = rst_n && (mem_count_q < DEPTH_C) && !read_issue;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid_q && out_ready;

`ifdef SRAM_FIFO_BYPASS_EN
  assign bypass = push && (mem_count_q == '0) && (state_q == IDLE) && (!out_valid_q || pop);
`else
  assign bypass = 1'b0;
`endif

  assign ram_write   = push && !bypass;
  assign ram_addr    = !rst_n ? '0 : (read_issue ? rd_ptr_q : wr_ptr_q);
  assign ram_data_in = in_data;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem_count_d = mem_count_q + (ADDR_WIDTH+1)'(ram_write) - (ADDR_WIDTH+1)'(read_issue);

    if (ram_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (read_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE:    if (read_issue) state_d = RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (pop) begin
      out_valid_d = 1'b0;
    end
    // RD_WAIT implies the output register is empty, so no pop can collide with this load.
    if (state_q == RD_WAIT) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_data_out;
    end
    if (bypass) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
    end

    count_d = mem_count_d + (ADDR_WIDTH+1)'(out_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: doc/sram_fifo_ctrl.md
# sram_fifo_ctrl

First-in first-out (FIFO) controller that sits directly upstream of the single-port `ram` block (`ADDR_WIDTH`/`DATA_WIDTH`/`DEPTH` = 8/8/256). It turns a valid/ready push stream into `ram` write cycles and turns stored words back into a valid/ready pop stream. It owns the read/write pointers, the occupancy count and the arbitration of the single `ram` port, and keeps one output word in a local register.

## Interface
- `ADDR_WIDTH`, 8, `ram` address width; `DEPTH` must equal 2^`ADDR_WIDTH`
- `DATA_WIDTH`, 8, word width
- `DEPTH`, 256, `ram` words used as FIFO storage
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  push request
- `in_ready`  out  1  push accepted when `in_valid && in_ready`
- `in_data`  in  `DATA_WIDTH`  push word
- `out_valid`  out  1  `out_data` holds oldest word
- `out_ready`  in  1  pop when `out_valid && out_ready`
- `out_data`  out  `DATA_WIDTH`  registered head word
- `count`  out  `ADDR_WIDTH`+1  words held (`ram` + output register), max `DEPTH`+1
- `ram_write`  out  1  to `ram` write
- `ram_addr`  out  `ADDR_WIDTH`  to `ram` addr
- `ram_data_in`  out  `DATA_WIDTH`  to `ram` data_in
- `ram_data_out`  in  `DATA_WIDTH`  from `ram` data_out; registered read, valid the cycle after the address is presented

## Operation
- State: `wr_ptr`, `rd_ptr` (`ADDR_WIDTH` bits, wrap `DEPTH`-1 -> 0), `mem_count` (0..`DEPTH`), FSM {`IDLE`, `RD_WAIT`}, `out_valid`/`out_data` register.
- `read_issue` = (FSM == `IDLE`) && !`out_valid` && (`mem_count` > 0).
- `in_ready` = (`mem_count` < `DEPTH`) && !`read_issue`. The read wins the port; the write stalls one cycle.
- `ram_write` = `in_valid && in_ready`; `ram_data_in` = `in_data`; `ram_addr` = `read_issue` ? `rd_ptr` : `wr_ptr`.
- On push: `wr_ptr`+1, `mem_count`+1.
- On `read_issue`: `rd_ptr`+1, `mem_count`-1, FSM -> `RD_WAIT`.
- `RD_WAIT`: `out_data` <= `ram_data_out`, `out_valid` <= 1, FSM -> `IDLE`. A push may be accepted in this cycle.
- On pop: `out_valid` <= 0, unless the same edge loads a new word.
- `count` = `mem_count` + `out_valid`, registered.
- Full (`mem_count` == `DEPTH`): `in_ready` = 0, and `in_valid` is ignored.
- Empty: `out_valid` = 0, and `out_ready` is ignored.
- Push and read in the same cycle is impossible by construction.
- A pop in the same cycle as a push is legal; each updates its own counter.

## Timing
- Reset (asynchronous on `rst_n` low) clears pointers, `mem_count`, `count`, `out_valid`, and sets `out_data` to 0 and FSM to `IDLE`.
- While `rst_n` = 0: `in_ready` = 0, `ram_write` = 0, `ram_addr` = 0, `ram_data_in` = `in_data`.
- Reset mid-`RD_WAIT` discards the in-flight read; the `ram` contents are not cleared but are considered invalid.
- Push-to-`out_valid` latency when empty: push at cycle t, `read_issue` at t+1, `RD_WAIT` at t+2, `out_valid` high at t+3.
- Streaming read throughput is one word per 3 cycles (pop, issue, `RD_WAIT`).
- `ram` timing: the write commits at the rising edge of the cycle in which `ram_write` = 1. A read address presented in cycle t yields `ram_data_out` in cycle t+1.

## Configuration
- `SRAM_FIFO_BYPASS_EN` defined: when `mem_count` == 0, FSM == `IDLE` and (!`out_valid` || pop this cycle), an accepted push loads `out_data` directly.
  - `ram_write` = 0 for that push; pointers and `mem_count` are unchanged; `out_valid` is high at t+1.
- Undefined: every word passes through the `ram`, with the latency given above.

## Test plan
- Reset, then push 0xAA, 0x55 with `out_ready` = 1 -> `out_data` 0xAA then 0x55; `count` returns to 0; `ram_write` asserted at `ram_addr` 0 and 1 (non-bypass build).
- Push 257 words (0x00..0xFF, 0x00) with `out_ready` = 0 -> `in_ready` falls once `mem_count` = 256; `count` = 257; words 258+ are not accepted.
- Drain the full FIFO -> 257 words in order with no duplicates or drops; `rd_ptr` wraps 255 -> 0; `out_valid` falls after the last word.
- Hold `in_valid` = 1 while `read_issue` is due -> `in_ready` = 0 that cycle only, and the write lands the next cycle at the unchanged `wr_ptr`.
- Assert `rst_n` = 0 during `RD_WAIT` with 3 words stored -> `out_valid` = 0, `count` = 0 immediately; the next push 0x2A pops as 0x2A.
- With `SRAM_FIFO_BYPASS_EN`, push 0x2A into the empty FIFO -> `out_valid` at t+1 with 0x2A, `ram_write` never asserted.
